axi_sram_write_slave: RTL and testbench

//  AXI4 write-channel responder at the slave end of the interconnect write path.

---
 rtl/axi_sram_write_slave.sv | 128 ++++++++++++
 tb/tb_axi_sram_write_slave.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/axi_sram_write_slave.sv
// AXI4 write-channel slave: one AW burst at a time, W beats to an SRAM byte-write port, one B response.
// Optional macro AXI_WSLV_BOUND_CHK_EN: beats whose word address >= MEM_DEPTH are dropped and flag SLVERR.
module axi_sram_write_slave #(
  parameter int ID_W      = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int MEM_AW    = 14,
  parameter int MEM_DEPTH = 16384
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       AWID,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic [LEN_W-1:0]      AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_W-1:0]       BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic                  mem_cs,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_di
);
  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } aw_req_t;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t            state, state_nxt;
  aw_req_t           aw_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic              err_q;       // sticky: WLAST mismatch or out-of-range beat
  logic              err_burst_q; // unsupported burst/size: beats are not written
  logic              aw_hs, w_hs, last_beat, bad_aw, oob;
  logic [MEM_AW-1:0] cur_word;

  assign aw_hs     = (state == S_IDLE) && AWVALID;
  assign w_hs      = (state == S_DATA) && WVALID;
  assign last_beat = (beat_cnt == aw_q.len);
  assign cur_word  = aw_q.addr[MEM_AW+1:2];
  assign bad_aw    = AWBURST[1] || (AWSIZE > 3'd2);

`ifdef AXI_WSLV_BOUND_CHK_EN
  assign oob = (32'(cur_word) >= MEM_DEPTH);
`else
  // No range check: the word index simply wraps modulo 2^MEM_AW.
  assign oob = (MEM_DEPTH < 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (aw_hs)              state_nxt = S_DATA;
      S_DATA: if (w_hs && last_beat)  state_nxt = S_RESP;
      S_RESP: if (BREADY)             state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  // Burst context: latched on AW, advanced per accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_q        <= '0;
      beat_cnt    <= '0;
      err_q       <= 1'b0;
      err_burst_q <= 1'b0;
    end else if (aw_hs) begin
      aw_q        <= {AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
      beat_cnt    <= '0;
      err_q       <= 1'b0;
      err_burst_q <= bad_aw;
    end else if (w_hs) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
      if (aw_q.burst == 2'b01)
        aw_q.addr <= aw_q.addr + (ADDR_W'(1) << aw_q.size);
      if ((WLAST != last_beat) || oob)
        err_q <= 1'b1;
    end
  end

  // Outputs: handshakes from state, SRAM port driven in the beat's own cycle
  always_comb begin
    AWREADY  = (state == S_IDLE);
    WREADY   = (state == S_DATA);
    BVALID   = (state == S_RESP);
    BID      = '0;
    BRESP    = 2'b00;
    mem_cs   = 1'b0;
    mem_we   = '0;
    mem_addr = '0;
    mem_di   = '0;
    if (state == S_RESP) begin
      BID   = aw_q.id;
      BRESP = (err_q || err_burst_q) ? 2'b10 : 2'b00;
    end
    if (w_hs) begin
      mem_cs   = !oob;
      mem_we   = (oob || err_burst_q) ? {STRB_W{1'b0}} : WSTRB;
      mem_addr = cur_word;
      mem_di   = WDATA;
    end
  end

endmodule

// File: tb/tb_axi_sram_write_slave.sv
// Directed + randomized bench for axi_sram_write_slave against a burst-level reference model.
module tb_axi_sram_write_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic        mem_cs;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_di;

  localparam int DEPTH = 16;
`ifdef AXI_WSLV_BOUND_CHK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  axi_sram_write_slave #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete burst; wlast_at<0 means WLAST on the true last beat.
  task automatic do_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] bt, input int wlast_at,
                          input int gap_beat, input int gap_len, input int bready_dly);
    bit bad = (bt > 2'd1) || (size > 3'd2);
    bit err = bad;
    @(negedge clk);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = bt; AWVALID = 1'b1;
    #1 chk("awready_idle", 32'(AWREADY), 32'd1);
    chk("wready_idle", 32'(WREADY), 32'd0);
    @(posedge clk); @(negedge clk);
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] b, word;
      bit lastexp, o;
      if (i == gap_beat) begin
        for (int g = 0; g < gap_len; g++) begin
          WVALID = 1'b0;
          #1 chk("gap_cs", 32'(mem_cs), 32'd0);
          chk("gap_wready", 32'(WREADY), 32'd1);
          @(negedge clk);
        end
      end
      lastexp = (i == int'(len));
      WVALID = 1'b1; WDATA = $urandom; WSTRB = 4'($urandom_range(15, 0));
      WLAST  = (wlast_at < 0) ? lastexp : (i == wlast_at);
      if (WLAST != lastexp) err = 1;
      b    = (bt == 2'b01) ? addr + 32'(i) * (32'd1 << size) : addr;
      word = (b >> 2) & 32'h3FFF;
      o    = BCHK && (word >= DEPTH);
      if (o) err = 1;
      #1 chk("mem_cs", 32'(mem_cs), 32'(!o));
      chk("mem_we", 32'(mem_we), (bad || o) ? 32'd0 : 32'(WSTRB));
      if (!o && !bad) chk("mem_addr", 32'(mem_addr), word);
      if (!o) chk("mem_di", mem_di, WDATA);
      @(posedge clk); @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
    #1 chk("bvalid", 32'(BVALID), 32'd1);
    chk("bid", 32'(BID), 32'(id));
    chk("bresp", 32'(BRESP), err ? 32'd2 : 32'd0);
    for (int d = 0; d < bready_dly; d++) begin
      AWVALID = 1'b1;
      @(posedge clk); @(negedge clk);
      #1 chk("bvalid_hold", 32'(BVALID), 32'd1);
      chk("bresp_hold", 32'(BRESP), err ? 32'd2 : 32'd0);
      chk("awready_resp", 32'(AWREADY), 32'd0);
    end
    @(negedge clk);
    AWVALID = 1'b0; BREADY = 1'b1;
    @(posedge clk); @(negedge clk);
    BREADY = 1'b0;
    #1 chk("bvalid_done", 32'(BVALID), 32'd0);
    chk("awready_back", 32'(AWREADY), 32'd1);
  endtask

  initial begin
    rst = 1'b0; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    #12;
    chk("rst_awready", 32'(AWREADY), 32'd1);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_bresp", 32'(BRESP), 32'd0);
    chk("rst_bid", 32'(BID), 32'd0);
    chk("rst_wready", 32'(WREADY), 32'd0);
    chk("rst_cs", 32'(mem_cs), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_di", mem_di, 32'd0);
    @(negedge clk); rst = 1'b1;

    // W presented before AW must wait
    @(negedge clk);
    WVALID = 1'b1; WDATA = 32'h1234_5678; WSTRB = 4'hF;
    #1 chk("w_before_aw_ready", 32'(WREADY), 32'd0);
    chk("w_before_aw_cs", 32'(mem_cs), 32'd0);
    WVALID = 1'b0;

    // Single beat
    do_burst(8'h15, 32'h0001_0010, 4'd0, 3'd2, 2'b01, -1, -1, 0, 0);
    // INCR LEN=3 with a 2-cycle W gap and BREADY low 3 cycles
    do_burst(8'h3C, 32'h0001_0000, 4'd3, 3'd2, 2'b01, -1, 2, 2, 3);
    // Early WLAST
    do_burst(8'h42, 32'h0000_0020, 4'd3, 3'd2, 2'b01, 1, -1, 0, 0);
    // Unsupported burst type, then oversize beat
    do_burst(8'h07, 32'h0000_0008, 4'd1, 3'd2, 2'b10, -1, -1, 0, 1);
    do_burst(8'h08, 32'h0000_0000, 4'd1, 3'd3, 2'b01, -1, -1, 0, 0);
    // Range edge at word 15, wrap at top of word space, FIXED, byte-size INCR
    do_burst(8'hA1, 32'h0000_003C, 4'd1, 3'd2, 2'b01, -1, -1, 0, 0);
    do_burst(8'hA2, 32'h0000_FFFC, 4'd1, 3'd2, 2'b01, -1, -1, 0, 0);
    do_burst(8'hA3, 32'h0000_0008, 4'd3, 3'd2, 2'b00, -1, -1, 0, 0);
    do_burst(8'hA4, 32'h0000_0001, 4'd3, 3'd0, 2'b01, -1, -1, 0, 0);

    for (int n = 0; n < 12; n++)
      do_burst(8'($urandom), $urandom & 32'h0000_FFFF, 4'($urandom_range(15, 0)),
               3'($urandom_range(2, 0)), 2'($urandom_range(1, 0)), -1,
               int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));

    // Reset in the middle of a burst: no response may appear afterwards
    @(negedge clk);
    AWID = 8'h99; AWADDR = 32'h10; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    @(posedge clk); @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b1; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF; WLAST = 1'b0;
    @(posedge clk); @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("midrst_bvalid", 32'(BVALID), 32'd0);
    chk("midrst_wready", 32'(WREADY), 32'd0);
    chk("midrst_cs", 32'(mem_cs), 32'd0);
    WVALID = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1 chk("postrst_awready", 32'(AWREADY), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk("postrst_no_b", 32'(BVALID), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
